fsm_cmd_arbiter: RTL and testbench



---
 rtl/fsm_cmd_arbiter.sv | 147 ++++++++++++++
 tb/tb_fsm_cmd_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter that gives N_REQ requesters exclusive, timed access to a
// shared mode FSM, with privileged commands reserved for requester 0.
module fsm_cmd_arbiter #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned CMD_W    = 3,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned PRIV_MIN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CMD_W-1:0] cmd,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [CMD_W-1:0]       rsp,
    output logic                   err,
    output logic                   busy,
    output logic [CMD_W-1:0]       fsm_in,
    input  logic [CMD_W-1:0]       fsm_out
);

    localparam int unsigned      PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CMD_W-1:0] PRIV_CMD  = CMD_W'(PRIV_MIN);
    localparam logic [2:0]       SETTLE_LD = 3'(SETTLE - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGrant   = 3'd1,
        StSettle  = 3'd2,
        StCapture = 3'd3
    } state_e;

    // Held as a raw vector so codes 4..7 can appear and be recovered from.
    logic [2:0]       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [CMD_W-1:0] rsp_q, rsp_d;
    logic [CMD_W-1:0] fsm_in_q, fsm_in_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             viol_q, viol_d;

    logic [CMD_W-1:0] cmd_arr [N_REQ];
    logic [N_REQ-1:0] owner_oh;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx;
    logic             found;

    for (genvar i = 0; i < N_REQ; i++) begin : g_cmd_unpack
        assign cmd_arr[i] = cmd[i*CMD_W +: CMD_W];
    end

    assign owner_oh = N_REQ'(1) << owner_q;

    // Round-robin search starting just after the last served owner.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = PTR_W'((int'(ptr_q) + k) % int'(N_REQ));
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cmd_d    = cmd_q;
        rsp_d    = rsp_q;
        fsm_in_d = fsm_in_q;
        cnt_d    = cnt_q;
        viol_d   = viol_q;
        gnt      = '0;
        done     = '0;
        err      = 1'b0;

        case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d = pick;
                    cmd_d   = cmd_arr[pick];
                    state_d = StGrant;
                end
            end
            StGrant: begin
                gnt = owner_oh;
                if (owner_q != '0 && cmd_q >= PRIV_CMD) begin
                    viol_d  = 1'b1;
                    rsp_d   = '0;
                    state_d = StCapture;
                end else begin
                    viol_d   = 1'b0;
                    fsm_in_d = cmd_q;
                    cnt_d    = SETTLE_LD;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    rsp_d   = fsm_out;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StCapture: begin
                done    = owner_oh;
                err     = viol_q;
                ptr_d   = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            ptr_q    <= PTR_W'(N_REQ - 1);
            cmd_q    <= '0;
            rsp_q    <= '0;
            fsm_in_q <= '0;
            cnt_q    <= '0;
            viol_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cmd_q    <= cmd_d;
            rsp_q    <= rsp_d;
            fsm_in_q <= fsm_in_d;
            cnt_q    <= cnt_d;
            viol_q   <= viol_d;
        end
    end

    assign rsp    = rsp_q;
    assign fsm_in = fsm_in_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_fsm_cmd_arbiter.sv
// Scoreboard bench for fsm_cmd_arbiter: expected transactions are queued as
// requests are driven and retired by a monitor on each done pulse.
module tb_fsm_cmd_arbiter;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned CMD_W = 3;

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*CMD_W-1:0] cmd;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [CMD_W-1:0]   rsp;
    logic               err;
    logic               busy;
    logic [CMD_W-1:0]   fsm_in;
    logic [CMD_W-1:0]   fsm_out;
    logic [CMD_W-1:0]   key;

    typedef struct {
        int owner;
        int rsp;
        int err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n;

    fsm_cmd_arbiter #(
        .N_REQ   (N_REQ),
        .CMD_W   (CMD_W),
        .SETTLE  (2),
        .PRIV_MIN(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .cmd    (cmd),
        .gnt    (gnt),
        .done   (done),
        .rsp    (rsp),
        .err    (err),
        .busy   (busy),
        .fsm_in (fsm_in),
        .fsm_out(fsm_out)
    );

    // Stand-in for the shared mode FSM: output is a keyed function of its input.
    assign fsm_out = fsm_in ^ key;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done == '0 && cycles < budget);
        check_eq("done_seen", 32'(done != '0), 32'd1);
    endtask

    task automatic push(input int owner, input int r, input int e);
        exp_t x;
        x.owner = owner;
        x.rsp   = r;
        x.err   = e;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (gnt != '0) begin
            if (sb.size() == 0) check_eq("unexp_gnt", 32'(gnt), 32'd0);
            else check_eq("gnt_owner", 32'(gnt), 32'(1) << sb[0].owner);
        end
        if (done != '0) begin
            if (sb.size() == 0) begin
                check_eq("unexp_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("done_owner", 32'(done), 32'(1) << e.owner);
                check_eq("rsp", 32'(rsp), 32'(e.rsp));
                check_eq("err", 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        cmd   = '0;
        key   = '0;
        cyc(3);
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_fsm_in", 32'(fsm_in), 32'd0);
        check_eq("rst_rsp", 32'(rsp), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // Single requester, cycle-exact latency.
        rst_n    = 1'b1;
        req      = 2'b01;
        cmd[2:0] = 3'd3;
        push(0, 3, 0);
        cyc(1);
        check_eq("t1_gnt_c1", 32'(gnt), 32'd1);
        check_eq("t1_busy_c1", 32'(busy), 32'd1);
        check_eq("t1_fsm_in_c1", 32'(fsm_in), 32'd0);
        req = 2'b00;
        cyc(1);
        check_eq("t1_fsm_in_c2", 32'(fsm_in), 32'd3);
        check_eq("t1_busy_c2", 32'(busy), 32'd1);
        cyc(1);
        check_eq("t1_done_c3", 32'(done), 32'd0);
        check_eq("t1_busy_c3", 32'(busy), 32'd1);
        cyc(1);
        check_eq("t1_done_c4", 32'(done), 32'd1);
        check_eq("t1_busy_c4", 32'(busy), 32'd1);
        cyc(1);
        check_eq("t1_busy_c5", 32'(busy), 32'd0);

        // Both requesting continuously: requester 1 is next after owner 0.
        key      = 3'b101;
        cmd[2:0] = 3'd1;
        cmd[5:3] = 3'd2;
        push(1, 7, 0);
        push(0, 4, 0);
        push(1, 7, 0);
        push(0, 4, 0);
        req = 2'b11;
        for (int i = 0; i < 4; i++) wait_done(20, n);
        req = 2'b00;
        cyc(3);
        check_eq("t2_idle", 32'(busy), 32'd0);
        check_eq("t2_fsm_in", 32'(fsm_in), 32'd1);

        // Privileged command from requester 1 is rejected.
        key      = 3'd0;
        cmd[5:3] = 3'd5;
        req      = 2'b10;
        push(1, 0, 1);
        cyc(1);
        check_eq("t3_gnt", 32'(gnt), 32'd2);
        req = 2'b00;
        cyc(1);
        check_eq("t3_done", 32'(done), 32'd2);
        check_eq("t3_err", 32'(err), 32'd1);
        check_eq("t3_fsm_in_kept", 32'(fsm_in), 32'd1);
        cyc(1);
        check_eq("t3_err_clear", 32'(err), 32'd0);

        // Same command from requester 0 is accepted.
        cmd[2:0] = 3'd5;
        req      = 2'b01;
        push(0, 5, 0);
        cyc(1);
        req = 2'b00;
        wait_done(20, n);
        check_eq("t3_fsm_in_priv", 32'(fsm_in), 32'd5);
        cyc(1);

        // Reset during SETTLE aborts without done.
        cmd[2:0] = 3'd2;
        req      = 2'b01;
        push(0, 2, 0);
        cyc(1);
        req = 2'b00;
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        sb.delete();
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_fsm_in", 32'(fsm_in), 32'd0);
        check_eq("t4_done", 32'(done), 32'd0);
        check_eq("t4_rsp", 32'(rsp), 32'd0);
        rst_n    = 1'b1;
        cmd[2:0] = 3'd6;
        cmd[5:3] = 3'd3;
        req      = 2'b11;
        push(0, 6, 0);
        cyc(1);
        check_eq("t4_gnt_prio", 32'(gnt), 32'd1);
        req = 2'b00;
        wait_done(20, n);
        cyc(1);
        req = 2'b10;
        push(1, 3, 0);
        cyc(1);
        req = 2'b00;
        wait_done(20, n);
        cyc(1);
        check_eq("t4_fsm_in", 32'(fsm_in), 32'd3);

        // Illegal state encoding recovers to IDLE without side effects.
        force dut.state_q = 3'd5;
        #1;
        check_eq("t5_busy_illegal", 32'(busy), 32'd1);
        check_eq("t5_next_idle", 32'(dut.state_d), 32'd0);
        check_eq("t5_gnt", 32'(gnt), 32'd0);
        check_eq("t5_done", 32'(done), 32'd0);
        cyc(1);
        check_eq("t5_fsm_in", 32'(fsm_in), 32'd3);
        release dut.state_q;
        cyc(1);
        check_eq("t5_recovered", 32'(busy), 32'd0);
        check_eq("t5_fsm_in_after", 32'(fsm_in), 32'd3);

        // One-cycle request pulse still completes, with a single grant.
        key      = 3'd2;
        cmd[2:0] = 3'd7;
        req      = 2'b01;
        push(0, 5, 0);
        cyc(1);
        check_eq("t6_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        wait_done(20, n);
        check_eq("t6_latency", 32'(n), 32'd3);
        cyc(6);
        check_eq("t6_idle", 32'(busy), 32'd0);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
